dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
// - Data-memory responder: the far end of the execute stage's load/store request interface.
// - Accepts one request per cycle in stage 4 (mem_op4/addr4/wdata4) and commits stores.
// - Returns formatted load data in stage 6: byte/half/word, sign/zero-extended.
// - Fixed latency, no back-pressure; the core reads rdata6 directly into its writeback mux.
// PARAMETERS
// - DEPTH_WORDS  1024  number of 32-bit words; word index = addr4[$clog2(DEPTH_WORDS)+1:2], upper bits ignored (wrap)
// - XLEN         32    data/address width; fixed at 32, checked by elaboration assert
// PORTS
// - clk               in   1   clock, rising edge
// - nrst              in   1   asynchronous active-low reset
// - mem_op4           in   4   op code (gp_mem_pkg::mem_op_t); MEM_NOP = idle
// - addr4             in   32  final byte address (base + offset already added by initiator)
// - wdata4            in   32  store data, right-aligned (SB uses [7:0], SH uses [15:0])
// - rdata6            out  32  formatted load data, 0 for stores/NOP/misaligned
// - rvalid6           out  1   1 when stage-6 slot holds a completed, aligned load
// - addr_misaligned6  out  1   1 when the stage-6 op was misaligned
// - parity_err6       out  1   load hit a parity mismatch (DMEM_PARITY_EN only; tied 0 otherwise)
// BEHAVIOUR
// - Op codes: NOP=0, LB=1, LH=2, LW=3, LBU=4, LHU=5, SB=6, SH=7, SW=8; 9..15 treated as NOP.
// - Byte order is little-endian; byte lane = addr4[1:0].
// - Misaligned: LH/LHU/SH when addr4[0]=1; LW/SW when addr4[1:0]!=0. Byte ops are never misaligned.
// - Misaligned store: no write. Misaligned load: rvalid6=0, rdata6=0. In both cases addr_misaligned6=1 two cycles later.
// - Cycle N (stage 4): decode, build byte enables, check alignment.
//   - Aligned store: written at the posedge ending cycle N.
//   - Load: array read launched at the same edge.
// - Cycle N+1 (stage 5): pipe5 holds op, byte lane, misaligned flag and raw read word.
// - Cycle N+2 (stage 6): pipe6 registers the lane-shifted, sign/zero-extended result.
// - Load latency = 2 cycles, throughput = 1 op/cycle.
// - Store at cycle N followed by a load of the same word at N+1 returns the new data (write precedes read by one edge). No forwarding logic is needed.
// - Store in stage 4 and load in stage 5/6 never conflict: only one array access occurs per edge.
// - Reset (async, any time): pipe5/pipe6 cleared; rdata6=0, rvalid6=0, addr_misaligned6=0, parity_err6=0.
//   - A store presented in the cycle nrst asserts is dropped.
//   - Array contents are NOT reset.
// - Out-of-range addresses alias modulo DEPTH_WORDS; no error is raised.
// CONFIGURATION
// - DMEM_PARITY_EN defined:
//   - One even-parity bit per byte is written alongside each byte-enabled lane.
//   - On a load, parity of the accessed bytes only is checked in stage 5.
//   - parity_err6 follows in stage 6 with rdata6 and rvalid6 unchanged.
// - DMEM_PARITY_EN undefined: no parity storage; parity_err6 is tied to 0.
// STRUCTURE
// - gp_mem_pkg: mem_op_t enum, MEM_* codes, is_load()/is_store() functions, byte-enable and extend helper functions.
// - Sub-module dmem_array:
//   - Synchronous single-port RAM, DEPTH_WORDS x 32, 4-bit byte-enable write, registered read.
//   - Under DMEM_PARITY_EN: +4 parity bits per word.
// - dmem_responder contains the decode, alignment check, pipe5/pipe6 and format logic.
// TESTING
// - SW 0xDEADBEEF @0x10, then LW @0x10 next cycle -> rdata6=0xDEADBEEF, rvalid6=1 exactly 2 cycles after the LW.
// - After the above: LB @0x13 -> 0xFFFFFFDE; LBU @0x13 -> 0x000000DE; LH @0x10 -> 0xFFFFBEEF; LHU @0x12 -> 0x0000DEAD.
// - SH 0x00001234 @0x12, then LW @0x10 -> 0x1234BEEF; SB 0x77 @0x11, then LW @0x10 -> 0x123477EF.
// - SW 0xFFFFFFFF @0x02 -> addr_misaligned6=1 at N+2; subsequent LW @0x00 shows word unchanged.
//   LH @0x11 -> addr_misaligned6=1, rvalid6=0, rdata6=0.
// - Back-to-back LW @0x10, 0x14, 0x18 on consecutive cycles -> three consecutive rvalid6 pulses, data in order.
//   Assert nrst during the 2nd LW -> all outputs 0 next cycle, no stale rvalid6 after release.
// - DMEM_PARITY_EN: SW 0xA5A5A5A5 @0x20, backdoor-flip parity bit of byte 1, LW @0x20 -> parity_err6=1.
//   LB @0x20 -> parity_err6=0 (byte 1 not accessed).

Source files
------------

// File: rtl/gp_mem_pkg.sv
// gp_mem_pkg: shared definitions for the data-memory load/store interface.
// - mem_op_t      : 4-bit memory op code; codes 9..15 are not enumerated and
//                   behave as MEM_NOP wherever they are decoded.
// - is_load/is_store, is_misaligned, byte_en, lane_data, extend_load helpers.
package gp_mem_pkg;

  typedef enum logic [3:0] {
    MEM_NOP = 4'd0,
    MEM_LB  = 4'd1,
    MEM_LH  = 4'd2,
    MEM_LW  = 4'd3,
    MEM_LBU = 4'd4,
    MEM_LHU = 4'd5,
    MEM_SB  = 4'd6,
    MEM_SH  = 4'd7,
    MEM_SW  = 4'd8
  } mem_op_t;

  function automatic logic is_load(mem_op_t op);
    return (op == MEM_LB) || (op == MEM_LH) || (op == MEM_LW) ||
           (op == MEM_LBU) || (op == MEM_LHU);
  endfunction

  function automatic logic is_store(mem_op_t op);
    return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
  endfunction

  // Byte ops can sit in any lane; halves need an even lane, words lane 0.
  function automatic logic is_misaligned(mem_op_t op, logic [1:0] lane);
    case (op)
      MEM_LH, MEM_LHU, MEM_SH: return lane[0];
      MEM_LW, MEM_SW:          return |lane;
      default:                 return 1'b0;
    endcase
  endfunction

  // Byte enables of the bytes an (aligned) access touches.
  function automatic logic [3:0] byte_en(mem_op_t op, logic [1:0] lane);
    case (op)
      MEM_LB, MEM_LBU, MEM_SB: return 4'b0001 << lane;
      MEM_LH, MEM_LHU, MEM_SH: return 4'b0011 << lane;
      MEM_LW, MEM_SW:          return 4'b1111;
      default:                 return 4'b0000;
    endcase
  endfunction

  // Replicate right-aligned store data into every lane; byte enables pick
  // which copy actually lands in the array.
  function automatic logic [31:0] lane_data(mem_op_t op, logic [31:0] wdata);
    case (op)
      MEM_SB:  return {4{wdata[7:0]}};
      MEM_SH:  return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

  // Shift the addressed bytes down to bit 0 and sign/zero-extend.
  function automatic logic [31:0] extend_load(mem_op_t op, logic [31:0] raw,
                                              logic [1:0] lane);
    logic        [31:0] sh;
    logic signed [7:0]  sb;
    logic signed [15:0] shw;
    sh  = raw >> {lane, 3'b000};
    sb  = $signed(sh[7:0]);
    shw = $signed(sh[15:0]);
    case (op)
      MEM_LB:  return 32'(sb);
      MEM_LBU: return {24'd0, sh[7:0]};
      MEM_LH:  return 32'(shw);
      MEM_LHU: return {16'd0, sh[15:0]};
      MEM_LW:  return raw;
      default: return 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array: synchronous single-port RAM, DEPTH_WORDS x 32 bits, with a
// 4-bit byte-enable write and a registered read. Contents are never reset.
// Optional feature macro: DMEM_PARITY_EN adds one even-parity bit per byte,
// written with each enabled byte and returned next to the read word.
// Ports:
//   clk    in  1   clock, rising edge
//   we     in  1   write strobe
//   be     in  4   byte enables for the write
//   re     in  1   read strobe
//   idx    in  AW  word index
//   wdata  in  32  lane-positioned write data
//   rdata  out 32  registered read word
//   rpar   out 4   registered parity bits (DMEM_PARITY_EN only)
module dmem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic          re,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
`ifdef DMEM_PARITY_EN
  output logic [3:0]    rpar,
`endif
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (re) rdata <= mem[idx];
  end

`ifdef DMEM_PARITY_EN
  logic [3:0] par_mem [DEPTH_WORDS];

  // Stored bit makes each byte plus its parity bit even.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) par_mem[idx][i] <= ^wdata[8*i +: 8];
      end
    end
    if (re) rpar <= par_mem[idx];
  end
`endif

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder at the far end of the execute
// stage's load/store interface. One request per cycle in stage 4, stores
// commit at the end of stage 4, formatted load data appears in stage 6
// (fixed 2-cycle latency, no back-pressure).
// Optional feature macro: DMEM_PARITY_EN (per-byte parity, reported on
// parity_err6); when undefined parity_err6 is tied to 0.
// Ports:
//   clk               in  1     clock, rising edge
//   nrst              in  1     asynchronous active-low reset
//   mem_op4           in  4     op code (mem_op_t), 9..15 act as NOP
//   addr4             in  XLEN  byte address
//   wdata4            in  XLEN  right-aligned store data
//   rdata6            out XLEN  formatted load data, 0 unless valid load
//   rvalid6           out 1     stage 6 holds a completed aligned load
//   addr_misaligned6  out 1     stage 6 op was misaligned
//   parity_err6       out 1     stage 6 load saw a parity mismatch
module dmem_responder
  import gp_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int XLEN        = 32
) (
  input  logic            clk,
  input  logic            nrst,
  input  mem_op_t         mem_op4,
  input  logic [XLEN-1:0] addr4,
  input  logic [XLEN-1:0] wdata4,
  output logic [XLEN-1:0] rdata6,
  output logic            rvalid6,
  output logic            addr_misaligned6,
  output logic            parity_err6
);

  localparam int AW = $clog2(DEPTH_WORDS);

  if (XLEN != 32) begin : g_xlen_chk
    $error("dmem_responder supports XLEN=32 only");
  end

  // ---- stage 4: decode, alignment, byte enables ----
  logic [1:0]    lane4;
  logic          mis4;
  logic          we4;
  logic          re4;
  logic [3:0]    be4;
  logic [AW-1:0] idx4;
  logic [31:0]   wd4;
  logic          unused_addr_hi;

  assign lane4 = addr4[1:0];
  assign mis4  = is_misaligned(mem_op4, lane4);
  assign be4   = byte_en(mem_op4, lane4);
  assign idx4  = addr4[AW+1:2];
  assign wd4   = lane_data(mem_op4, wdata4);
  // Gating with nrst drops a store presented while reset is asserted.
  assign we4   = is_store(mem_op4) && !mis4 && nrst;
  assign re4   = is_load(mem_op4) && !mis4;
  // Address bits above the array wrap silently.
  assign unused_addr_hi = ^addr4[XLEN-1:AW+2];

  logic [31:0] raw5;
`ifdef DMEM_PARITY_EN
  logic [3:0]  rpar5;
`endif

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_array (
    .clk  (clk),
    .we   (we4),
    .be   (be4),
    .re   (re4),
    .idx  (idx4),
    .wdata(wd4),
`ifdef DMEM_PARITY_EN
    .rpar (rpar5),
`endif
    .rdata(raw5)
  );

  // ---- stage 5: op, lane and misalignment travel with the raw read word ----
  mem_op_t    op5;
  logic [1:0] lane5;
  logic       mis5;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      op5   <= MEM_NOP;
      lane5 <= 2'd0;
      mis5  <= 1'b0;
    end else begin
      op5   <= mem_op4;
      lane5 <= lane4;
      mis5  <= mis4;
    end
  end

  logic ld_ok5;
  assign ld_ok5 = is_load(op5) && !mis5;

`ifdef DMEM_PARITY_EN
  // Only the bytes the load actually reads are checked.
  logic [3:0] calc_par5;
  logic       perr5;

  always_comb begin
    calc_par5 = '0;
    for (int i = 0; i < 4; i++) calc_par5[i] = ^raw5[8*i +: 8];
  end
  assign perr5 = ld_ok5 && |(byte_en(op5, lane5) & (calc_par5 ^ rpar5));
`endif

  // ---- stage 6: formatted result ----
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rdata6           <= '0;
      rvalid6          <= 1'b0;
      addr_misaligned6 <= 1'b0;
    end else begin
      rdata6           <= ld_ok5 ? extend_load(op5, raw5, lane5) : '0;
      rvalid6          <= ld_ok5;
      addr_misaligned6 <= mis5;
    end
  end

`ifdef DMEM_PARITY_EN
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) parity_err6 <= 1'b0;
    else       parity_err6 <= perr5;
  end
`else
  assign parity_err6 = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
  import gp_mem_pkg::*;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  mem_op_t     mem_op4 = MEM_NOP;
  logic [31:0] addr4 = '0;
  logic [31:0] wdata4 = '0;
  logic [31:0] rdata6;
  logic        rvalid6;
  logic        addr_misaligned6;
  logic        parity_err6;

  dmem_responder #(.DEPTH_WORDS(1024), .XLEN(32)) dut (
    .clk             (clk),
    .nrst            (nrst),
    .mem_op4         (mem_op4),
    .addr4           (addr4),
    .wdata4          (wdata4),
    .rdata6          (rdata6),
    .rvalid6         (rvalid6),
    .addr_misaligned6(addr_misaligned6),
    .parity_err6     (parity_err6)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        rvalid;
    logic        mis;
    logic        perr;
    string       name;
  } exp_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rvalid;
    logic        mis;
    string       name;
  } vec_t;

  exp_t        pipe_q[$];
  logic [7:0]  model_mem [0:4095];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_outputs(exp_t e);
    chk({e.name, ".rdata6"}, rdata6, e.rdata);
    chk({e.name, ".rvalid6"}, {31'd0, rvalid6}, {31'd0, e.rvalid});
    chk({e.name, ".addr_misaligned6"}, {31'd0, addr_misaligned6}, {31'd0, e.mis});
    chk({e.name, ".parity_err6"}, {31'd0, parity_err6}, {31'd0, e.perr});
  endtask

  function automatic exp_t zero_exp(string name);
    exp_t e;
    e.rdata = '0; e.rvalid = 1'b0; e.mis = 1'b0; e.perr = 1'b0; e.name = name;
    return e;
  endfunction

  // Reference model: byte-addressed little-endian memory of 4096 bytes.
  function automatic exp_t predict(logic [3:0] op, logic [31:0] addr,
                                   logic [31:0] wdata, string name);
    exp_t        e;
    int          size;
    bit          ld, sgn;
    int          base;
    logic [63:0] v;
    e = zero_exp(name);
    base = int'(addr[11:0]);
    size = 0; ld = 0; sgn = 0;
    case (op)
      4'd1: begin size = 1; ld = 1; sgn = 1; end
      4'd2: begin size = 2; ld = 1; sgn = 1; end
      4'd3: begin size = 4; ld = 1; sgn = 1; end
      4'd4: begin size = 1; ld = 1; end
      4'd5: begin size = 2; ld = 1; end
      4'd6: size = 1;
      4'd7: size = 2;
      4'd8: size = 4;
      default: size = 0;
    endcase
    if (size == 0) return e;
    if (base % size != 0) begin
      e.mis = 1'b1;
      return e;
    end
    if (!ld) begin
      for (int b = 0; b < size; b++) model_mem[base + b] = wdata[8*b +: 8];
    end else begin
      v = '0;
      for (int b = 0; b < size; b++) v = v | (64'(model_mem[base + b]) << (8*b));
      if (sgn && v[8*size-1]) v = v | ~((64'd1 << (8*size)) - 64'd1);
      e.rdata  = v[31:0];
      e.rvalid = 1'b1;
    end
    return e;
  endfunction

  // Outputs seen at a negedge belong to the op driven two negedges earlier.
  task automatic step(logic [3:0] op, logic [31:0] addr, logic [31:0] wdata, exp_t e);
    @(negedge clk);
    if (pipe_q.size() >= 2) chk_outputs(pipe_q.pop_front());
    mem_op4 = mem_op_t'(op);
    addr4   = addr;
    wdata4  = wdata;
    pipe_q.push_back(e);
  endtask

  task automatic mstep(logic [3:0] op, logic [31:0] addr, logic [31:0] wdata, string name);
    exp_t e;
    e = predict(op, addr, wdata, name);
    step(op, addr, wdata, e);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  vec_t tbl [20];

  initial begin
    exp_t e;
    logic [3:0]  rop;
    logic [31:0] raddr;

    tbl[0]  = '{4'd8, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0, 1'b0, "sw_10"};
    tbl[1]  = '{4'd3, 32'h10,   32'h0,        32'hDEADBEEF, 1'b1, 1'b0, "lw_10"};
    tbl[2]  = '{4'd1, 32'h13,   32'h0,        32'hFFFFFFDE, 1'b1, 1'b0, "lb_13"};
    tbl[3]  = '{4'd4, 32'h13,   32'h0,        32'h000000DE, 1'b1, 1'b0, "lbu_13"};
    tbl[4]  = '{4'd2, 32'h10,   32'h0,        32'hFFFFBEEF, 1'b1, 1'b0, "lh_10"};
    tbl[5]  = '{4'd5, 32'h12,   32'h0,        32'h0000DEAD, 1'b1, 1'b0, "lhu_12"};
    tbl[6]  = '{4'd7, 32'h12,   32'hFFFF1234, 32'h0,        1'b0, 1'b0, "sh_12"};
    tbl[7]  = '{4'd3, 32'h10,   32'h0,        32'h1234BEEF, 1'b1, 1'b0, "lw_after_sh"};
    tbl[8]  = '{4'd6, 32'h11,   32'hAAAAAA77, 32'h0,        1'b0, 1'b0, "sb_11"};
    tbl[9]  = '{4'd3, 32'h10,   32'h0,        32'h123477EF, 1'b1, 1'b0, "lw_after_sb"};
    tbl[10] = '{4'd8, 32'h02,   32'hFFFFFFFF, 32'h0,        1'b0, 1'b1, "sw_misaligned"};
    tbl[11] = '{4'd3, 32'h00,   32'h0,        32'hC0DE0000, 1'b1, 1'b0, "lw_00_unchanged"};
    tbl[12] = '{4'd2, 32'h11,   32'h0,        32'h0,        1'b0, 1'b1, "lh_misaligned"};
    tbl[13] = '{4'd0, 32'h10,   32'h0,        32'h0,        1'b0, 1'b0, "nop"};
    tbl[14] = '{4'd3, 32'h10,   32'h0,        32'h123477EF, 1'b1, 1'b0, "b2b_lw_10"};
    tbl[15] = '{4'd3, 32'h14,   32'h0,        32'hC0DE0005, 1'b1, 1'b0, "b2b_lw_14"};
    tbl[16] = '{4'd3, 32'h18,   32'h0,        32'hC0DE0006, 1'b1, 1'b0, "b2b_lw_18"};
    tbl[17] = '{4'd9, 32'h10,   32'h0,        32'h0,        1'b0, 1'b0, "op9_nop"};
    tbl[18] = '{4'd3, 32'h1010, 32'h0,        32'h123477EF, 1'b1, 1'b0, "lw_alias"};
    tbl[19] = '{4'd5, 32'h03,   32'h0,        32'h0,        1'b0, 1'b1, "lhu_misaligned"};

    // Reset state
    repeat (2) @(negedge clk);
    chk_outputs(zero_exp("reset"));
    nrst = 1'b1;

    // Known contents for the first 64 words
    for (int w = 0; w < 64; w++)
      mstep(4'd8, 32'(w * 4), 32'hC0DE0000 | 32'(w), "init");

    // Directed vectors
    for (int i = 0; i < 20; i++) begin
      void'(predict(tbl[i].op, tbl[i].addr, tbl[i].wdata, tbl[i].name));
      e.rdata = tbl[i].rdata; e.rvalid = tbl[i].rvalid; e.mis = tbl[i].mis;
      e.perr = 1'b0; e.name = tbl[i].name;
      step(tbl[i].op, tbl[i].addr, tbl[i].wdata, e);
    end
    mstep(4'd0, 32'h0, 32'h0, "drain");
    mstep(4'd0, 32'h0, 32'h0, "drain");
    mstep(4'd0, 32'h0, 32'h0, "drain");

    // Reset during back-to-back loads, with a store during reset
    mstep(4'd3, 32'h10, 32'h0, "rst_lw1");
    mstep(4'd3, 32'h14, 32'h0, "rst_lw2");
    #2 nrst = 1'b0;
    pipe_q.delete();
    #1 chk_outputs(zero_exp("rst_async"));
    @(negedge clk);
    mem_op4 = MEM_SW; addr4 = 32'h18; wdata4 = 32'h55555555;
    @(negedge clk);
    chk_outputs(zero_exp("rst_hold"));
    nrst = 1'b1;
    mem_op4 = MEM_NOP; addr4 = '0; wdata4 = '0;
    pipe_q.push_back(zero_exp("post_rst0"));
    pipe_q.push_back(zero_exp("post_rst1"));
    mstep(4'd0, 32'h0, 32'h0, "post_rst2");
    mstep(4'd3, 32'h18, 32'h0, "lw_18_store_dropped");

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      rop   = 4'($urandom_range(0, 15));
      raddr = ($urandom & 32'hFFFFF000) | (32'($urandom_range(0, 63)) << 2) |
              32'($urandom_range(0, 3));
      mstep(rop, raddr, $urandom, "rand");
    end

`ifdef DMEM_PARITY_EN
    mstep(4'd8, 32'h20, 32'hA5A5A5A5, "par_sw");
    mstep(4'd0, 32'h0, 32'h0, "par_nop");
    mstep(4'd0, 32'h0, 32'h0, "par_nop");
    dut.u_array.par_mem[8][1] = ~dut.u_array.par_mem[8][1];
    e = predict(4'd3, 32'h20, 32'h0, "par_lw");
    e.perr = 1'b1;
    step(4'd3, 32'h20, 32'h0, e);
    mstep(4'd1, 32'h20, 32'h0, "par_lb_clean");
`endif

    mstep(4'd0, 32'h0, 32'h0, "final");
    mstep(4'd0, 32'h0, 32'h0, "final");
    mstep(4'd0, 32'h0, 32'h0, "final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
